// File: rtl/blake2b_sigma_sched_if.sv
// Sequencer <-> register-stage handshake and index bus.
//   start_i       : start a compression (sampled only while idle)
//   stall_i       : downstream not ready, freezes the step walk
//   load_o        : one-cycle strobe to capture m/h
//   mindex_bus_o  : 8 message-word indices, slot i at [(i+1)*W-1 : i*W]
//   round_o/step_o: current round and step (0 = column, 1 = diagonal)
//   valid_o/last_o: step outputs valid / final step of the compression
//   busy_o/done_o : compression in progress / one-cycle completion pulse
interface blake2b_sigma_sched_if #(
    parameter int unsigned MIndex_Width = 4
);
    logic                      start_i;
    logic                      stall_i;
    logic                      load_o;
    logic [8*MIndex_Width-1:0] mindex_bus_o;
    logic [3:0]                round_o;
    logic                      step_o;
    logic                      valid_o;
    logic                      last_o;
    logic                      busy_o;
    logic                      done_o;

    // Sequencer side
    modport master (
        input  start_i, stall_i,
        output load_o, mindex_bus_o, round_o, step_o,
               valid_o, last_o, busy_o, done_o
    );

    // Register-stage / controller side
    modport slave (
        output start_i, stall_i,
        input  load_o, mindex_bus_o, round_o, step_o,
               valid_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/blake2b_sigma_sched.sv
// BLAKE2b round/step sequencer. A start in IDLE produces a one-cycle load
// strobe, then ROUNDS x {column, diagonal} steps, each presenting the 8
// SIGMA message-word indices for the four G functions, then a done pulse.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-low
//   bus   : blake2b_sigma_sched_if master modport (see interface header)
module blake2b_sigma_sched #(
    parameter int unsigned ROUNDS       = 12,
    parameter int unsigned MIndex_Width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    blake2b_sigma_sched_if.master bus
);

    localparam int unsigned BUS_W   = 8 * MIndex_Width;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned LAST_RD = ROUNDS - 1;
    localparam int unsigned LAST_ROW = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 step_q, step_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 is_last;

    logic                 load_c, valid_c, last_c, busy_c, done_c, step_c;
    logic [ROUND_W-1:0]   round_c;
    logic [BUS_W-1:0]     mindex_c;
    logic [63:0]          row_bits;
    logic [31:0]          half_bits;

    // SIGMA row as 16 packed 4-bit entries, entry j at bits [4j+3:4j]
    function automatic logic [63:0] sigma_row(input logic [ROW_W-1:0] row);
        logic [63:0] r;
        case (row)
            4'd0:    r = 64'hFEDC_BA98_7654_3210;
            4'd1:    r = 64'h357B_20C1_6DF9_84AE;
            4'd2:    r = 64'h4917_63EA_DF25_0C8B;
            4'd3:    r = 64'h8F04_A562_EBCD_1397;
            4'd4:    r = 64'hD386_CB1E_FA42_7509;
            4'd5:    r = 64'h91EF_57D4_38B0_A6C2;
            4'd6:    r = 64'hB289_3670_A4DE_F15C;
            4'd7:    r = 64'hA268_4F05_931C_E7BD;
            4'd8:    r = 64'h5A41_7D2C_803B_9EF6;
            4'd9:    r = 64'h0DC3_E9BF_5167_482A;
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    assign is_last = (round_q == ROUND_W'(LAST_RD)) && step_q;

    // State and step counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            round_q <= '0;
            step_q  <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
            row_q   <= row_d;
        end
    end

    // Next state and counter advance
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        step_d  = step_q;
        row_d   = row_q;
        case (state_q)
            IDLE: if (bus.start_i) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (!bus.stall_i) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else if (!step_q) begin
                        step_d = 1'b1;
                    end else begin
                        step_d  = 1'b0;
                        round_d = round_q + ROUND_W'(1);
                        // Row tracks round mod 10 without a divider
                        row_d   = (row_q == ROW_W'(LAST_ROW)) ? '0 : row_q + ROW_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Counters start from zero on every new compression
        if (state_q != RUN) begin
            round_d = '0;
            step_d  = 1'b0;
            row_d   = '0;
        end
    end

    // Output values for the coming cycle, decoded from next state/counters
    always_comb begin
        load_c   = (state_d == LOAD);
        valid_c  = (state_d == RUN);
        busy_c   = (state_d != IDLE);
        done_c   = (state_d == DONE);
        round_c  = valid_c ? round_d : '0;
        step_c   = valid_c & step_d;
        last_c   = valid_c && (round_d == ROUND_W'(LAST_RD)) && step_d;
        row_bits = sigma_row(row_d);
        half_bits = step_d ? row_bits[63:32] : row_bits[31:0];
        mindex_c = '0;
        if (valid_c) begin
            for (int i = 0; i < 8; i++) begin
                mindex_c[i*MIndex_Width +: MIndex_Width] = MIndex_Width'(half_bits[i*4 +: 4]);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.load_o       <= 1'b0;
            bus.valid_o      <= 1'b0;
            bus.last_o       <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.step_o       <= 1'b0;
            bus.round_o      <= '0;
            bus.mindex_bus_o <= '0;
        end else begin
            bus.load_o       <= load_c;
            bus.valid_o      <= valid_c;
            bus.last_o       <= last_c;
            bus.busy_o       <= busy_c;
            bus.done_o       <= done_c;
            bus.step_o       <= step_c;
            bus.round_o      <= round_c;
            bus.mindex_bus_o <= mindex_c;
        end
    end

endmodule

// File: doc/blake2b_sigma_sched.md
Name: blake2b_sigma_sched

Overview:
Round/step sequencer directly upstream of the message/state register stage. On a start pulse it issues a one-cycle load strobe so m/h are captured. It then walks ROUNDS rounds × 2 steps (column, diagonal). Each step it drives the 8 SIGMA message-word indices onto mindex_bus_o, which the register stage uses to select the 8 words for the four G functions, and it signals completion at the end.

Parameters:
ROUNDS, 12, number of compression rounds; legal range 1..15.
MIndex_Width, 4 (from defines.v), width of one message-word index.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
start_i  input  1  start compression; sampled only in IDLE
stall_i  input  1  downstream not ready; freezes the sequencer in RUN
load_o  output  1  one-cycle strobe: capture m_i/h_i into the register stage
mindex_bus_o  output  8*MIndex_Width  index i at bits [(i+1)*MIndex_Width-1 : i*MIndex_Width]
round_o  output  4  current round number, 0..ROUNDS-1
step_o  output  1  0 = column step, 1 = diagonal step
valid_o  output  1  mindex_bus_o/round_o/step_o are valid this cycle
last_o  output  1  current step is the final step (round ROUNDS-1, diagonal)
busy_o  output  1  high in LOAD, RUN and DONE
done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset: rst=0 asynchronously forces IDLE. All outputs go to 0, and round, step and sigma-row counters go to 0. This also applies mid-operation; no partial done_o is produced. Operation resumes on the first clk edge after rst=1.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE: start_i=1 -> LOAD.
  - LOAD: always -> RUN (one cycle; load_o=1).
  - RUN, stall_i=0 and not last -> advance step.
  - RUN, stall_i=0 and last -> DONE.
  - RUN, stall_i=1 -> hold all outputs and counters unchanged.
  - DONE: always -> IDLE (one cycle; done_o=1).
- start_i is ignored outside IDLE.
- Step advance: step 0 -> 1. From step 1, go to step 0 with round+1, and sigma row +1 wrapping 9 -> 0. The sigma row is a separate counter; no modulo divider.
- mindex_bus_o selection:
  - step 0: SIGMA[row][0..7].
  - step 1: SIGMA[row][8..15].
  - Index i goes to slot i.
  - Outside RUN: 0.
- SIGMA is the 10-row BLAKE2b permutation table held as constants. Rows 0 and 1 as examples:
  - Row 0: 0..15.
  - Row 1: 14,10,4,8,9,15,13,6,1,12,0,2,11,7,5,3.
- Timing, no stall: start_i high at cycle t.
  - t+1: load_o=1.
  - t+2 .. t+1+2*ROUNDS: valid_o=1, one step per cycle.
  - t+2+2*ROUNDS: done_o=1.
  - Next cycle: IDLE; a new start_i is accepted there.
- last_o=1 only when valid_o=1, round_o=ROUNDS-1 and step_o=1.
- Stall during the last step: last_o and valid_o are held, and DONE is entered only after stall_i=0.
- stall_i has no effect in IDLE, LOAD or DONE.

Test Plan:
- Reset, then start_i pulse at cycle 0 with stall_i=0 -> load_o=1 at cycle 1. Cycle 2: valid_o=1, round 0, step 0, mindex slots = 0,1,2,3,4,5,6,7. Cycle 3: slots = 8..15, step 1. Cycle 26: done_o=1. Cycle 27: busy_o=0.
- Same run, check cycles 4 and 5 (round 1) -> slots 14,10,4,8,9,15,13,6, then 1,12,0,2,11,7,5,3. Check round 10 (cycle 22) -> slots 0..7, i.e. the row wrapped. Check round 11 diagonal (cycle 25) -> slots 1,12,0,2,11,7,5,3 with last_o=1.
- Hold stall_i=1 for 3 cycles starting at round 5 step 1 -> outputs frozen for those 3 cycles. done_o is delayed to cycle 29. The total count of valid&&!stall cycles is 24.
- start_i held high continuously -> start_i ignored while busy. Second run's load_o appears 2 cycles after the first done_o (IDLE cycle, then LOAD).
- Assert rst=0 asynchronously at round 7 -> all outputs 0 immediately, no done_o. After release, a start_i pulse gives a clean round-0 sequence.
- ROUNDS=1 build -> exactly 2 valid steps, last_o on the second, done_o at t+4.
